// File: rtl/ex_stage_if.sv
// Decode-to-EX-to-WB bundle for the execute stage: decode-side operands/controls
// plus the registered EX/WB results and the stall back to decode.
interface ex_stage_if #(
    parameter int DATA_W   = 32,
    parameter int REG_ID_W = 5
);
    logic                id_valid;
    logic [DATA_W-1:0]   operand_a;
    logic [DATA_W-1:0]   operand_b;
    logic [DATA_W-1:0]   imm;
    logic                alu_src;
    logic [3:0]          alu_op;
    logic                write_to_regfile_from_id;
    logic                mem_write_from_id;
    logic                mem_read_from_id;
    logic                mem_to_reg_from_id;
    logic [DATA_W-1:0]   mem_write_data_from_id;
    logic [REG_ID_W-1:0] writeback_reg_id_from_id;

    logic                stall_to_id;
    logic [DATA_W-1:0]   alu_result;
    logic                write_to_regfile_to_wb;
    logic                mem_write_to_wb;
    logic                mem_read_to_wb;
    logic                mem_to_reg_to_wb;
    logic [DATA_W-1:0]   mem_write_data_to_wb;
    logic [REG_ID_W-1:0] writeback_reg_id_to_wb;

    modport master (
        output id_valid, operand_a, operand_b, imm, alu_src, alu_op,
               write_to_regfile_from_id, mem_write_from_id, mem_read_from_id,
               mem_to_reg_from_id, mem_write_data_from_id, writeback_reg_id_from_id,
        input  stall_to_id, alu_result, write_to_regfile_to_wb, mem_write_to_wb,
               mem_read_to_wb, mem_to_reg_to_wb, mem_write_data_to_wb,
               writeback_reg_id_to_wb
    );

    modport slave (
        input  id_valid, operand_a, operand_b, imm, alu_src, alu_op,
               write_to_regfile_from_id, mem_write_from_id, mem_read_from_id,
               mem_to_reg_from_id, mem_write_data_from_id, writeback_reg_id_from_id,
        output stall_to_id, alu_result, write_to_regfile_to_wb, mem_write_to_wb,
               mem_read_to_wb, mem_to_reg_to_wb, mem_write_data_to_wb,
               writeback_reg_id_to_wb
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus iterative MUL into the EX/WB register.
// Define EX_DIV_EN to add the iterative DIVU/REMU unit (otherwise those ops return 0).
module ex_stage #(
    parameter int DATA_W   = 32,
    parameter int REG_ID_W = 5
) (
    input  logic      clk,
    input  logic      rst,
    ex_stage_if.slave ex
);
    localparam int              SH_W  = $clog2(DATA_W);
    localparam int              CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
`ifdef EX_DIV_EN
    localparam logic [3:0] OP_DIVU = 4'd11;
    localparam logic [3:0] OP_REMU = 4'd12;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL
`ifdef EX_DIV_EN
        , S_DIV
`endif
    } state_t;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    count_reg, count_next;

    logic [DATA_W-1:0]   b_sel;
    logic [SH_W-1:0]     sh;
    logic [DATA_W-1:0]   alu_out;
    logic                is_multi;
    logic                load;
    logic                stall_c;
    logic                finish;
    logic [DATA_W-1:0]   fin_res;

    // Iterative operand state: MUL uses op_a as shifting multiplicand, op_b as shifting
    // multiplier, acc as partial product; DIV uses op_a as quotient/dividend shifter,
    // op_b as divisor, acc as partial remainder.
    logic [DATA_W-1:0]   op_a_reg, op_b_reg, acc_reg;
    logic [DATA_W-1:0]   mul_sum;
    logic                lat_wr_reg, lat_mw_reg, lat_mr_reg, lat_m2r_reg;
    logic [DATA_W-1:0]   lat_wdata_reg;
    logic [REG_ID_W-1:0] lat_rd_reg;

`ifdef EX_DIV_EN
    logic                is_rem_reg;
    logic [DATA_W:0]     rem_shift;
    logic                div_ok;
    logic [DATA_W-1:0]   rem_step;
    logic [DATA_W-1:0]   quo_step;
`endif

    logic [DATA_W-1:0]   res_reg, res_next;
    logic                wr_reg, wr_next;
    logic                mw_reg, mw_next;
    logic                mr_reg, mr_next;
    logic                m2r_reg, m2r_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;
    logic [REG_ID_W-1:0] rd_reg, rd_next;

    assign b_sel = ex.alu_src ? ex.imm : ex.operand_b;
    assign sh    = b_sel[SH_W-1:0];

    always_comb begin
        alu_out = '0;
        case (ex.alu_op)
            OP_ADD:  alu_out = ex.operand_a + b_sel;
            OP_SUB:  alu_out = ex.operand_a - b_sel;
            OP_AND:  alu_out = ex.operand_a & b_sel;
            OP_OR:   alu_out = ex.operand_a | b_sel;
            OP_XOR:  alu_out = ex.operand_a ^ b_sel;
            OP_SLL:  alu_out = ex.operand_a << sh;
            OP_SRL:  alu_out = ex.operand_a >> sh;
            OP_SRA:  alu_out = $signed(ex.operand_a) >>> sh;
            OP_SLT:  alu_out = {{(DATA_W-1){1'b0}}, $signed(ex.operand_a) < $signed(b_sel)};
            OP_SLTU: alu_out = {{(DATA_W-1){1'b0}}, ex.operand_a < b_sel};
            default: alu_out = '0;
        endcase
    end

    always_comb begin
        is_multi = (ex.alu_op == OP_MUL);
`ifdef EX_DIV_EN
        if (ex.alu_op == OP_DIVU || ex.alu_op == OP_REMU)
            is_multi = 1'b1;
`endif
    end

    assign mul_sum = acc_reg + (op_b_reg[0] ? op_a_reg : '0);

`ifdef EX_DIV_EN
    // A zero divisor always "fits", so the quotient fills with ones and the dividend
    // shifts whole into the remainder -- the required divide-by-zero results for free.
    assign rem_shift = {acc_reg, op_a_reg[DATA_W-1]};
    assign div_ok    = (rem_shift >= {1'b0, op_b_reg});
    assign rem_step  = div_ok ? DATA_W'(rem_shift - {1'b0, op_b_reg}) : rem_shift[DATA_W-1:0];
    assign quo_step  = {op_a_reg[DATA_W-2:0], div_ok};
`endif

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        load       = 1'b0;
        stall_c    = 1'b0;
        finish     = 1'b0;
        fin_res    = '0;
        res_next   = '0;
        wr_next    = 1'b0;
        mw_next    = 1'b0;
        mr_next    = 1'b0;
        m2r_next   = 1'b0;
        wdata_next = '0;
        rd_next    = '0;

        case (state_reg)
            S_IDLE: begin
                if (ex.id_valid) begin
                    if (is_multi) begin
                        stall_c    = 1'b1;
                        load       = 1'b1;
                        count_next = '0;
                        state_next = S_MUL;
`ifdef EX_DIV_EN
                        if (ex.alu_op != OP_MUL)
                            state_next = S_DIV;
`endif
                    end else begin
                        res_next   = alu_out;
                        wr_next    = ex.write_to_regfile_from_id;
                        mw_next    = ex.mem_write_from_id;
                        mr_next    = ex.mem_read_from_id;
                        m2r_next   = ex.mem_to_reg_from_id;
                        wdata_next = ex.mem_write_data_from_id;
                        rd_next    = ex.writeback_reg_id_from_id;
                    end
                end
            end
            S_MUL: begin
                if (count_reg == LAST) begin
                    finish  = 1'b1;
                    fin_res = mul_sum;
                end else begin
                    stall_c    = 1'b1;
                    count_next = count_reg + CNT_W'(1);
                end
            end
`ifdef EX_DIV_EN
            S_DIV: begin
                if (count_reg == LAST) begin
                    finish  = 1'b1;
                    fin_res = is_rem_reg ? rem_step : quo_step;
                end else begin
                    stall_c    = 1'b1;
                    count_next = count_reg + CNT_W'(1);
                end
            end
`endif
            default: state_next = S_IDLE;
        endcase

        if (finish) begin
            state_next = S_IDLE;
            count_next = '0;
            res_next   = fin_res;
            wr_next    = lat_wr_reg;
            mw_next    = lat_mw_reg;
            mr_next    = lat_mr_reg;
            m2r_next   = lat_m2r_reg;
            wdata_next = lat_wdata_reg;
            rd_next    = lat_rd_reg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_a_reg      <= '0;
            op_b_reg      <= '0;
            acc_reg       <= '0;
            lat_wr_reg    <= 1'b0;
            lat_mw_reg    <= 1'b0;
            lat_mr_reg    <= 1'b0;
            lat_m2r_reg   <= 1'b0;
            lat_wdata_reg <= '0;
            lat_rd_reg    <= '0;
`ifdef EX_DIV_EN
            is_rem_reg    <= 1'b0;
`endif
        end else if (load) begin
            op_a_reg      <= ex.operand_a;
            op_b_reg      <= b_sel;
            acc_reg       <= '0;
            lat_wr_reg    <= ex.write_to_regfile_from_id;
            lat_mw_reg    <= ex.mem_write_from_id;
            lat_mr_reg    <= ex.mem_read_from_id;
            lat_m2r_reg   <= ex.mem_to_reg_from_id;
            lat_wdata_reg <= ex.mem_write_data_from_id;
            lat_rd_reg    <= ex.writeback_reg_id_from_id;
`ifdef EX_DIV_EN
            is_rem_reg    <= (ex.alu_op == OP_REMU);
`endif
        end else if (state_reg == S_MUL) begin
            acc_reg  <= mul_sum;
            op_a_reg <= op_a_reg << 1;
            op_b_reg <= op_b_reg >> 1;
        end
`ifdef EX_DIV_EN
        else if (state_reg == S_DIV) begin
            acc_reg  <= rem_step;
            op_a_reg <= quo_step;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_reg   <= '0;
            wr_reg    <= 1'b0;
            mw_reg    <= 1'b0;
            mr_reg    <= 1'b0;
            m2r_reg   <= 1'b0;
            wdata_reg <= '0;
            rd_reg    <= '0;
        end else begin
            res_reg   <= res_next;
            wr_reg    <= wr_next;
            mw_reg    <= mw_next;
            mr_reg    <= mr_next;
            m2r_reg   <= m2r_next;
            wdata_reg <= wdata_next;
            rd_reg    <= rd_next;
        end
    end

    // Stall is combinational from decode inputs, so hold it low while reset is asserted.
    assign ex.stall_to_id            = stall_c & rst;
    assign ex.alu_result             = res_reg;
    assign ex.write_to_regfile_to_wb = wr_reg;
    assign ex.mem_write_to_wb        = mw_reg;
    assign ex.mem_read_to_wb         = mr_reg;
    assign ex.mem_to_reg_to_wb       = m2r_reg;
    assign ex.mem_write_data_to_wb   = wdata_reg;
    assign ex.writeback_reg_id_to_wb = rd_reg;
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, memory controls, multi-cycle MUL (and
// DIVU/REMU when EX_DIV_EN is defined), and reset during a multi-cycle op.
module tb_ex_stage;
    localparam int DW = 32;
    localparam int RW = 5;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_DIVU = 4'd11;
    localparam logic [3:0] OP_REMU = 4'd12;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ex_stage_if #(.DATA_W(DW), .REG_ID_W(RW)) bus ();

    ex_stage #(.DATA_W(DW), .REG_ID_W(RW)) dut (
        .clk (clk),
        .rst (rst),
        .ex  (bus)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic        src;
        logic [31:0] exp;
    } alu_vec_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } mc_vec_t;

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] im, input logic src,
                         input logic wr, input logic mw, input logic mr, input logic m2r,
                         input logic [31:0] wd, input logic [4:0] rd);
        bus.id_valid                 = v;
        bus.alu_op                   = op;
        bus.operand_a                = a;
        bus.operand_b                = b;
        bus.imm                      = im;
        bus.alu_src                  = src;
        bus.write_to_regfile_from_id = wr;
        bus.mem_write_from_id        = mw;
        bus.mem_read_from_id         = mr;
        bus.mem_to_reg_from_id       = m2r;
        bus.mem_write_data_from_id   = wd;
        bus.writeback_reg_id_from_id = rd;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        drive(1'b1, OP_MUL, 32'd3, 32'd4, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h55, 5'd7);
        #12;
        $display("[reset] alu_result=%h wr=%b stall=%b", bus.alu_result,
                 bus.write_to_regfile_to_wb, bus.stall_to_id);
        checks++;
        if (bus.alu_result !== 32'h0) begin
            errors++; $display("FAIL reset_alu_result: got %h expected 0", bus.alu_result);
        end
        checks++;
        if ({bus.write_to_regfile_to_wb, bus.mem_write_to_wb, bus.mem_read_to_wb,
             bus.mem_to_reg_to_wb} !== 4'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b%b%b%b expected 0000",
                bus.write_to_regfile_to_wb, bus.mem_write_to_wb, bus.mem_read_to_wb,
                bus.mem_to_reg_to_wb);
        end
        checks++;
        if (bus.mem_write_data_to_wb !== 32'h0 || bus.writeback_reg_id_to_wb !== 5'd0) begin
            errors++; $display("FAIL reset_data: got %h/%0d expected 0/0",
                bus.mem_write_data_to_wb, bus.writeback_reg_id_to_wb);
        end
        checks++;
        if (bus.stall_to_id !== 1'b0) begin
            errors++; $display("FAIL reset_stall: got %b expected 0", bus.stall_to_id);
        end
        drive(1'b0, OP_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 5'd0);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_alu;
        alu_vec_t v[$];
        v.push_back('{OP_ADD,  32'd5,         32'd7,         32'd0,  1'b0, 32'd12});
        v.push_back('{OP_SRA,  32'h80000000,  32'd0,         32'd4,  1'b1, 32'hF8000000});
        v.push_back('{OP_SLTU, 32'd1,         32'hFFFFFFFF,  32'd0,  1'b0, 32'd1});
        v.push_back('{OP_SUB,  32'd5,         32'd7,         32'd0,  1'b0, 32'hFFFFFFFE});
        v.push_back('{OP_AND,  32'hF0F0F0F0,  32'h0FF00FF0,  32'd0,  1'b0, 32'h00F000F0});
        v.push_back('{OP_OR,   32'hF0F0F0F0,  32'h0FF00FF0,  32'd0,  1'b0, 32'hFFF0FFF0});
        v.push_back('{OP_XOR,  32'hF0F0F0F0,  32'h0FF00FF0,  32'd0,  1'b0, 32'hFF00FF00});
        v.push_back('{OP_SLL,  32'd1,         32'd0,         32'd31, 1'b1, 32'h80000000});
        v.push_back('{OP_SRL,  32'h80000000,  32'h24,        32'd0,  1'b0, 32'h08000000});
        v.push_back('{OP_SLT,  32'hFFFFFFFF,  32'd1,         32'd0,  1'b0, 32'd1});
        v.push_back('{OP_SLT,  32'd1,         32'hFFFFFFFF,  32'd0,  1'b0, 32'd0});
        v.push_back('{4'd13,   32'd9,         32'd9,         32'd0,  1'b0, 32'd0});
        v.push_back('{OP_ADD,  32'hFFFFFFFF,  32'd1,         32'd0,  1'b0, 32'd0});
        v.push_back('{OP_ADD,  32'd10,        32'd99,        32'd5,  1'b1, 32'd15});
        // Issued back to back: one new instruction every cycle, no idle gaps.
        foreach (v[i]) begin
            drive(1'b1, v[i].op, v[i].a, v[i].b, v[i].imm, v[i].src, 1'b1, 1'b0, 1'b0, 1'b0,
                  32'd0, 5'(i + 1));
            #1;
            checks++;
            if (bus.stall_to_id !== 1'b0) begin
                errors++; $display("FAIL alu%0d_stall: got %b expected 0", i, bus.stall_to_id);
            end
            tick();
            $display("[alu] op=%0d a=%h b=%h imm=%h src=%b -> %h rd=%0d", v[i].op, v[i].a,
                     v[i].b, v[i].imm, v[i].src, bus.alu_result, bus.writeback_reg_id_to_wb);
            checks++;
            if (bus.alu_result !== v[i].exp) begin
                errors++; $display("FAIL alu%0d_result: got %h expected %h", i,
                                   bus.alu_result, v[i].exp);
            end
            checks++;
            if (bus.write_to_regfile_to_wb !== 1'b1 || bus.writeback_reg_id_to_wb !== 5'(i + 1)) begin
                errors++; $display("FAIL alu%0d_wb: got wr=%b rd=%0d expected wr=1 rd=%0d", i,
                                   bus.write_to_regfile_to_wb, bus.writeback_reg_id_to_wb, i + 1);
            end
        end
    endtask

    task automatic test_bubble;
        drive(1'b0, OP_ADD, 32'd3, 32'd4, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hBEEF, 5'd9);
        tick();
        $display("[bubble] alu_result=%h wr=%b mw=%b", bus.alu_result,
                 bus.write_to_regfile_to_wb, bus.mem_write_to_wb);
        checks++;
        if (bus.alu_result !== 32'h0 || bus.mem_write_data_to_wb !== 32'h0 ||
            bus.writeback_reg_id_to_wb !== 5'd0) begin
            errors++; $display("FAIL bubble_data: got %h/%h/%0d expected 0/0/0",
                bus.alu_result, bus.mem_write_data_to_wb, bus.writeback_reg_id_to_wb);
        end
        checks++;
        if ({bus.write_to_regfile_to_wb, bus.mem_write_to_wb, bus.mem_read_to_wb,
             bus.mem_to_reg_to_wb} !== 4'b0) begin
            errors++; $display("FAIL bubble_ctrl: got %b%b%b%b expected 0000",
                bus.write_to_regfile_to_wb, bus.mem_write_to_wb, bus.mem_read_to_wb,
                bus.mem_to_reg_to_wb);
        end
    endtask

    task automatic test_mem;
        drive(1'b1, OP_ADD, 32'h100, 32'd0, 32'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hDEAD, 5'd0);
        tick();
        $display("[store] addr=%h data=%h mw=%b wr=%b", bus.alu_result,
                 bus.mem_write_data_to_wb, bus.mem_write_to_wb, bus.write_to_regfile_to_wb);
        checks++;
        if (bus.alu_result !== 32'h108 || bus.mem_write_data_to_wb !== 32'hDEAD) begin
            errors++; $display("FAIL store_addr_data: got %h/%h expected 00000108/0000dead",
                bus.alu_result, bus.mem_write_data_to_wb);
        end
        checks++;
        if ({bus.write_to_regfile_to_wb, bus.mem_write_to_wb, bus.mem_read_to_wb,
             bus.mem_to_reg_to_wb} !== 4'b0100) begin
            errors++; $display("FAIL store_ctrl: got %b%b%b%b expected 0100",
                bus.write_to_regfile_to_wb, bus.mem_write_to_wb, bus.mem_read_to_wb,
                bus.mem_to_reg_to_wb);
        end
        drive(1'b1, OP_ADD, 32'h200, 32'd0, 32'hFFFFFFFC, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'd0, 5'd12);
        tick();
        $display("[load] addr=%h rd=%0d mr=%b m2r=%b", bus.alu_result,
                 bus.writeback_reg_id_to_wb, bus.mem_read_to_wb, bus.mem_to_reg_to_wb);
        checks++;
        if (bus.alu_result !== 32'h1FC || bus.writeback_reg_id_to_wb !== 5'd12) begin
            errors++; $display("FAIL load_addr: got %h/%0d expected 000001fc/12",
                bus.alu_result, bus.writeback_reg_id_to_wb);
        end
        checks++;
        if ({bus.write_to_regfile_to_wb, bus.mem_write_to_wb, bus.mem_read_to_wb,
             bus.mem_to_reg_to_wb} !== 4'b1011) begin
            errors++; $display("FAIL load_ctrl: got %b%b%b%b expected 1011",
                bus.write_to_regfile_to_wb, bus.mem_write_to_wb, bus.mem_read_to_wb,
                bus.mem_to_reg_to_wb);
        end
    endtask

    task automatic test_multicycle;
        mc_vec_t v[$];
        int stall_cnt;
        int bad_bubbles;
        v.push_back('{OP_MUL,  32'h00010003, 32'h00020005, 5'd9,  32'h000B000F});
        v.push_back('{OP_MUL,  32'hFFFFFFFF, 32'd3,        5'd10, 32'hFFFFFFFD});
`ifdef EX_DIV_EN
        v.push_back('{OP_DIVU, 32'd100,      32'd7,        5'd11, 32'd14});
        v.push_back('{OP_REMU, 32'd100,      32'd7,        5'd12, 32'd2});
        v.push_back('{OP_DIVU, 32'h12345678, 32'd0,        5'd13, 32'hFFFFFFFF});
        v.push_back('{OP_REMU, 32'd9,        32'd0,        5'd14, 32'd9});
        v.push_back('{OP_DIVU, 32'hFFFFFFFF, 32'd1,        5'd15, 32'hFFFFFFFF});
        v.push_back('{OP_REMU, 32'hFFFFFFFF, 32'd10,       5'd16, 32'd5});
`endif
        foreach (v[i]) begin
            drive(1'b1, v[i].op, v[i].a, v[i].b, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                  32'h5A5A, v[i].rd);
            stall_cnt   = 0;
            bad_bubbles = 0;
            for (int c = 0; c < 33; c++) begin
                #1;
                if (bus.stall_to_id === 1'b1) stall_cnt++;
                tick();
                if (c < 32 && (bus.write_to_regfile_to_wb !== 1'b0 || bus.alu_result !== 32'h0))
                    bad_bubbles++;
            end
            $display("[multi] op=%0d a=%h b=%h -> %h rd=%0d stalls=%0d", v[i].op, v[i].a,
                     v[i].b, bus.alu_result, bus.writeback_reg_id_to_wb, stall_cnt);
            checks++;
            if (stall_cnt != 32) begin
                errors++; $display("FAIL multi%0d_stall_cycles: got %0d expected 32", i, stall_cnt);
            end
            checks++;
            if (bad_bubbles != 0) begin
                errors++; $display("FAIL multi%0d_bubbles: got %0d non-bubble cycles expected 0",
                                   i, bad_bubbles);
            end
            checks++;
            if (bus.alu_result !== v[i].exp) begin
                errors++; $display("FAIL multi%0d_result: got %h expected %h", i,
                                   bus.alu_result, v[i].exp);
            end
            checks++;
            if (bus.writeback_reg_id_to_wb !== v[i].rd || bus.write_to_regfile_to_wb !== 1'b1 ||
                bus.mem_write_data_to_wb !== 32'h5A5A) begin
                errors++; $display("FAIL multi%0d_ctrl: got rd=%0d wr=%b wd=%h expected rd=%0d wr=1 wd=00005a5a",
                    i, bus.writeback_reg_id_to_wb, bus.write_to_regfile_to_wb,
                    bus.mem_write_data_to_wb, v[i].rd);
            end
            // The very next instruction must be taken without stalling.
            drive(1'b1, OP_ADD, 32'd2, 32'd3, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 5'd7);
            #1;
            checks++;
            if (bus.stall_to_id !== 1'b0) begin
                errors++; $display("FAIL multi%0d_next_stall: got %b expected 0", i, bus.stall_to_id);
            end
            tick();
            $display("[next] ADD 2+3 -> %h rd=%0d", bus.alu_result, bus.writeback_reg_id_to_wb);
            checks++;
            if (bus.alu_result !== 32'd5 || bus.writeback_reg_id_to_wb !== 5'd7) begin
                errors++; $display("FAIL multi%0d_next_add: got %h/%0d expected 00000005/7", i,
                                   bus.alu_result, bus.writeback_reg_id_to_wb);
            end
        end
    endtask

`ifndef EX_DIV_EN
    task automatic test_div_disabled;
        logic [3:0] ops [2];
        ops[0] = OP_DIVU;
        ops[1] = OP_REMU;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, ops[i], 32'd100, 32'd7, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 5'd4);
            #1;
            checks++;
            if (bus.stall_to_id !== 1'b0) begin
                errors++; $display("FAIL nodiv%0d_stall: got %b expected 0", i, bus.stall_to_id);
            end
            tick();
            $display("[nodiv] op=%0d 100,7 -> %h wr=%b", ops[i], bus.alu_result,
                     bus.write_to_regfile_to_wb);
            checks++;
            if (bus.alu_result !== 32'h0 || bus.write_to_regfile_to_wb !== 1'b1) begin
                errors++; $display("FAIL nodiv%0d_result: got %h wr=%b expected 0 wr=1", i,
                                   bus.alu_result, bus.write_to_regfile_to_wb);
            end
        end
    endtask
`endif

    task automatic test_reset_mid_mul;
        drive(1'b1, OP_MUL, 32'd3, 32'd4, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hAA, 5'd6);
        repeat (11) tick();
        checks++;
        if (bus.stall_to_id !== 1'b1) begin
            errors++; $display("FAIL midrst_pre_stall: got %b expected 1", bus.stall_to_id);
        end
        rst = 1'b0;
        #1;
        $display("[midrst] stall=%b alu_result=%h wr=%b", bus.stall_to_id, bus.alu_result,
                 bus.write_to_regfile_to_wb);
        checks++;
        if (bus.stall_to_id !== 1'b0) begin
            errors++; $display("FAIL midrst_stall: got %b expected 0", bus.stall_to_id);
        end
        checks++;
        if (bus.alu_result !== 32'h0 || bus.write_to_regfile_to_wb !== 1'b0 ||
            bus.writeback_reg_id_to_wb !== 5'd0) begin
            errors++; $display("FAIL midrst_outputs: got %h/%b/%0d expected 0/0/0",
                bus.alu_result, bus.write_to_regfile_to_wb, bus.writeback_reg_id_to_wb);
        end
        #2;
        rst = 1'b1;
        drive(1'b1, OP_ADD, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 5'd4);
        #1;
        checks++;
        if (bus.stall_to_id !== 1'b0) begin
            errors++; $display("FAIL midrst_add_stall: got %b expected 0", bus.stall_to_id);
        end
        tick();
        $display("[midrst] ADD 1+1 -> %h rd=%0d", bus.alu_result, bus.writeback_reg_id_to_wb);
        checks++;
        if (bus.alu_result !== 32'd2 || bus.writeback_reg_id_to_wb !== 5'd4) begin
            errors++; $display("FAIL midrst_add: got %h/%0d expected 00000002/4",
                               bus.alu_result, bus.writeback_reg_id_to_wb);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_bubble();
        test_mem();
        test_multicycle();
`ifndef EX_DIV_EN
        test_div_disabled();
`endif
        test_reset_mid_mul();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
